// File: rtl/stream_mux_nx1_if.sv
// Bundle of the stream multiplexer's channel and output signals.
// slave  : the multiplexer's view (accepts the N input streams, drives the output stream).
// master : the environment's view (producers + downstream consumer).
// Signals:
//   in_data   [N_IN*WIDTH]  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  [N_IN]        per-channel data valid
//   in_ready  [N_IN]        per-channel accept (combinational)
//   ctrl      [SEL_W]       explicit channel select (explicit-select mode only)
//   out_data  [WIDTH]       registered output data
//   out_valid               registered output valid
//   out_ready               downstream accept
//   sel_idx   [SEL_W]       registered index of the channel held in out_data
//   sel_err                 registered one-cycle out-of-range select pulse
interface stream_mux_nx1_if #(
   parameter int N_IN  = 6,
   parameter int WIDTH = 8
);
   localparam int SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic [SEL_W-1:0]      ctrl;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      sel_idx;
   logic                  sel_err;

   modport slave (
      input  in_data, in_valid, ctrl, out_ready,
      output in_ready, out_data, out_valid, sel_idx, sel_err
   );

   modport master (
      output in_data, in_valid, ctrl, out_ready,
      input  in_ready, out_data, out_valid, sel_idx, sel_err
   );
endinterface

// File: rtl/stream_mux_nx1.sv
// N:1 stream multiplexer with one registered output stage.
// MODE=0 selects the channel named by ctrl; MODE=1 arbitrates round-robin.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream_mux_nx1_if.slave (channel inputs, ctrl, output stream, sel_idx, sel_err)
//
// Handshake: a word moves across an interface on a clk edge where its valid
// and ready are both high. valid never depends on ready. in_ready depends
// combinationally on out_ready (and on in_valid in MODE=1); out_valid and
// out_data come only from registers.
module stream_mux_nx1 #(
   parameter int N_IN  = 6,
   parameter int WIDTH = 8,
   parameter int MODE  = 0
) (
   input logic            clk,
   input logic            rst_n,
   stream_mux_nx1_if.slave bus
);
   localparam int SEL_W = $clog2(N_IN);
   localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_IN);

   // Output stage state; out_valid is the state itself.
   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic             state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             err_q, err_d;

   logic             load_en;
   logic             ctrl_ok;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [N_IN-1:0]  ready;
   logic             xfer;

   // Stage can take a new word when empty or when its word leaves this edge.
   assign load_en = (state_q == ST_EMPTY) | bus.out_ready;
   assign ctrl_ok = {1'b0, bus.ctrl} < N_LIM;

   always_comb begin : grant_logic
      logic [SEL_W:0] c;
      c         = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      if (MODE == 0) begin
         grant_vld = ctrl_ok;
         grant_idx = bus.ctrl;
      end else begin
         // Walk from farthest to nearest so the channel closest after ptr wins.
         for (int k = N_IN; k >= 1; k--) begin
            c = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (c >= N_LIM) c = c - N_LIM;
            if (bus.in_valid[c[SEL_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = c[SEL_W-1:0];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         ready[i] = load_en & grant_vld & (grant_idx == SEL_W'(i));
      end
   end

   assign xfer         = |(bus.in_valid & ready);
   assign bus.in_ready = ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      err_d   = (MODE == 0) & load_en & ~ctrl_ok & (|bus.in_valid);
      if (xfer) begin
         state_d = ST_FULL;
         data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
         idx_d   = grant_idx;
         if (MODE != 0) ptr_d = grant_idx;
      end else if (bus.out_ready) begin
         // Drain without reload: data and index keep their last value.
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         idx_q   <= '0;
         ptr_q   <= SEL_W'(N_IN - 1);  // channel 0 gets first priority
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.out_data  = data_q;
   assign bus.sel_idx   = idx_q;
   assign bus.sel_err   = err_q;
endmodule
